hub75_bcm_scheduler: RTL and testbench
======================================

# hub75_bcm_scheduler

Sequences a 64x64 HUB75 LED panel (two 32-row halves driven in parallel) with binary-coded modulation (BCM) for multi-bit colour. Per row pair and per bit plane it reads the framebuffer, shifts one bit of each pixel into the panel, latches it, then unblanks for a plane-weighted time. It replaces the free-running scan counter between the framebuffer RAM and the panel pins; the board top only maps its outputs to the header pins.

## Interface
- WIDTH, 64: columns per row (power of two).
- ROWS, 32: row pairs; sets addry width clog2(ROWS).
- BITS, 4: colour depth per channel (bit planes).
- BASE, 8: display cycles for plane 0; plane p shows BASE<<p cycles.

Ports:
- clk  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high.
- enable  in  1  run request, sampled in IDLE and at frame end.
- fb_addr  out  clog2(ROWS)+clog2(WIDTH)  {row, column} read address.
- fb_data0  in  3*BITS  upper-half pixel {B,G,R}, each BITS wide (B in MSBs); 1-cycle read latency.
- fb_data1  in  3*BITS  lower-half pixel, same packing and latency.
- rgb0, rgb1  out  3  {B,G,R} bit of the current plane, upper and lower half.
- sclk  out  1  panel shift clock; panel samples on rising edge.
- latch  out  1  panel latch strobe.
- blank  out  1  panel output-enable, active-high blank.
- addry  out  clog2(ROWS)  row pair currently displayed.
- frame_start  out  1  one-cycle pulse at start of each frame.

## Operation
- States: IDLE, SHIFT, LATCH, SHOW.
- IDLE: blank=1, sclk=0, latch=0. With enable=1, go to SHIFT with row=0, plane=0 and pulse frame_start in the same cycle.
- SHIFT: column k=0..WIDTH-1. Each column takes 2 cycles. The shifted data is bit `plane` of each channel of fb_data0/fb_data1. blank stays 1 throughout.
- LATCH: 1 cycle with latch=1 and blank=1. addry is loaded with row in this cycle.
- SHOW: blank=0 for BASE<<plane cycles.
- After SHOW:
  - If plane<BITS-1: plane++ and go to SHIFT.
  - Otherwise plane=0 and row++.
  - If the row wraps from ROWS-1 to 0 (frame end): go to SHIFT with a frame_start pulse if enable=1, else go to IDLE.
- enable dropping mid-frame has no effect until frame end. The current frame always completes.
- addry changes only in LATCH, never while blank=0.
- Row and plane counters wrap modulo ROWS and BITS.
- No overlap of shifting and display; brightness duty is intentionally below 100%.
- Reset behaviour: reset takes priority in any state. The next cycle shows the reset values: state IDLE, blank=1, sclk=0, latch=0, rgb0=rgb1=0, addry=0, fb_addr=0, frame_start=0, all counters 0.

## Timing
- SHIFT cycle offsets are relative to SHIFT entry, t=0.
- fb_addr={row,k} is held stable during cycles 2k and 2k+1.
- rgb0/rgb1 for column k are driven in cycles 2k+2 and 2k+3.
- sclk=1 only in cycle 2k+3. Data is therefore stable one cycle before and during sclk high.
- SHIFT lasts 2*WIDTH+2 cycles. It is followed by 1 LATCH cycle, then BASE<<p SHOW cycles.
- Per row: BITS*(2*WIDTH+3) + BASE*(2^BITS-1) cycles. With defaults: 4*131+8*15 = 644 cycles.
- Per frame: 32*644 = 20608 cycles, about 1213 Hz at 25 MHz.
- frame_start is coincident with the first SHIFT cycle of row 0, plane 0.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Shared package hub75_pkg holds:
  - the state enum;
  - RGB bit-index constants (R=0, G=1, B=2);
  - the fb_data channel-slice helper;
  - the default WIDTH/ROWS/BITS/BASE.
- One sub-module, hub75_plane_timer:
  - loadable down-counter for the SHOW duration;
  - inputs: plane index and start;
  - output: done pulse on the last SHOW cycle.
- Everything else stays in the scheduler: FSM, column/phase counter, row/plane counters, output registers.

## Test plan
- Reset then enable=1 -> frame_start pulses at cycle 1 after enable is sampled. First fb_addr=0. Exactly 64 sclk pulses precede the first latch. blank=1 until after the latch.
- Framebuffer pixel (row 3, col 5) upper = B:0,G:0,R:0b1010, all others 0 -> rgb0 bit R=1 only on the 6th sclk of the plane-1 and plane-3 shifts of row 3. rgb1 stays 0.
- Measure SHOW lengths with defaults -> blank low for exactly 8, 16, 32, 64 cycles per row. Row period is 644 cycles and frame period is 20608 cycles.
- Check addry -> increments only in latch cycles, goes 0..31 then wraps to 0, never changes while blank=0.
- Deassert enable at row 10 -> frame completes through row 31, then IDLE with blank=1. No further frame_start pulses.
- Assert reset during SHOW of row 7, plane 2 -> next cycle blank=1, latch=sclk=0, addry=0, rgb=0. Re-enable restarts from row 0, plane 0.

Source files
------------

// File: rtl/hub75_pkg.sv
`default_nettype none
// ==========================================================================
// hub75_pkg -- shared state encoding, channel indices and default geometry
// Revision: 1.0
// ==========================================================================
package hub75_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2,
    ST_SHOW  = 2'd3
  } state_e;

  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_ROWS  = 32;
  localparam int DEF_BITS  = 4;
  localparam int DEF_BASE  = 8;

  // Low bit of a colour channel inside a packed {B,G,R} framebuffer word.
  function automatic int chan_lo(input int chan, input int bits);
    return chan * bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hub75_plane_timer.sv
`default_nettype none
// ==========================================================================
// hub75_plane_timer -- SHOW-phase down-counter, done on the last SHOW cycle
// Revision: 1.0
// ==========================================================================
module hub75_plane_timer
  import hub75_pkg::*;
#(
  parameter int BITS = DEF_BITS,
  parameter int BASE = DEF_BASE,
  parameter int PL_W = $clog2(BITS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [PL_W-1:0] plane,
  output logic            done
);

  localparam int CW = $clog2(BASE << (BITS - 1)) + 1;

  logic [CW-1:0] count_q, count_d;
  logic          active_q, active_d;

  always_comb begin
    count_d  = count_q;
    active_d = active_q;
    if (start) begin
      count_d  = (CW'(BASE) << plane) - CW'(1);
      active_d = 1'b1;
    end else if (active_q) begin
      if (count_q == '0) begin
        active_d = 1'b0;
      end else begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      active_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      active_q <= active_d;
    end
  end

  assign done = active_q && (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/hub75_bcm_scheduler.sv
`default_nettype none
// ==========================================================================
// hub75_bcm_scheduler -- HUB75 row/bit-plane scan with binary-coded modulation
// Revision: 1.0
// ==========================================================================
module hub75_bcm_scheduler
  import hub75_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ROWS  = DEF_ROWS,
  parameter int BITS  = DEF_BITS,
  parameter int BASE  = DEF_BASE
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  enable,
  output logic [$clog2(ROWS)+$clog2(WIDTH)-1:0] fb_addr,
  input  logic [3*BITS-1:0]                     fb_data0,
  input  logic [3*BITS-1:0]                     fb_data1,
  output logic [2:0]                            rgb0,
  output logic [2:0]                            rgb1,
  output logic                                  sclk,
  output logic                                  latch,
  output logic                                  blank,
  output logic [$clog2(ROWS)-1:0]               addry,
  output logic                                  frame_start
);

  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(ROWS);
  localparam int PL_W  = $clog2(BITS);
  localparam int CNT_W = $clog2(2 * WIDTH + 2);
  localparam int R_LO  = chan_lo(CH_R, BITS);
  localparam int G_LO  = chan_lo(CH_G, BITS);
  localparam int B_LO  = chan_lo(CH_B, BITS);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(2 * WIDTH + 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
  localparam logic [PL_W-1:0]  PLANE_LAST = PL_W'(BITS - 1);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [PL_W-1:0]          plane_q, plane_d;
  logic [ROW_W+COL_W-1:0]   fb_addr_q, fb_addr_d;
  logic [2:0]               rgb0_q, rgb0_d, rgb1_q, rgb1_d;
  logic                     sclk_q, sclk_d, latch_q, latch_d;
  logic                     blank_q, blank_d, frame_start_q, frame_start_d;
  logic [ROW_W-1:0]         addry_q, addry_d;

  logic [CNT_W-1:0]         cnt_inc;
  logic [BITS-1:0]          r0, g0, b0, r1, g1, b1;
  logic                     show_start, show_done;

  assign r0 = fb_data0[R_LO +: BITS];
  assign g0 = fb_data0[G_LO +: BITS];
  assign b0 = fb_data0[B_LO +: BITS];
  assign r1 = fb_data1[R_LO +: BITS];
  assign g1 = fb_data1[G_LO +: BITS];
  assign b1 = fb_data1[B_LO +: BITS];

  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign show_start = (state_q == ST_LATCH);

  hub75_plane_timer #(
    .BITS (BITS),
    .BASE (BASE)
  ) u_plane_timer (
    .clk   (clk),
    .reset (reset),
    .start (show_start),
    .plane (plane_q),
    .done  (show_done)
  );

  // Shift phase t: address column t/2 in even/odd pairs; RAM data for a column
  // arrives on the odd cycle and is registered so it is stable around sclk.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    row_d         = row_q;
    plane_d       = plane_q;
    fb_addr_d     = fb_addr_q;
    rgb0_d        = rgb0_q;
    rgb1_d        = rgb1_q;
    addry_d       = addry_q;
    frame_start_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d       = ST_SHIFT;
          cnt_d         = '0;
          row_d         = '0;
          plane_d       = '0;
          fb_addr_d     = '0;
          frame_start_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_LATCH;
          cnt_d   = '0;
          addry_d = row_q;
        end else begin
          cnt_d     = cnt_inc;
          fb_addr_d = {row_q, cnt_inc[COL_W:1]};
          if (cnt_q[0]) begin
            rgb0_d = {b0[plane_q], g0[plane_q], r0[plane_q]};
            rgb1_d = {b1[plane_q], g1[plane_q], r1[plane_q]};
          end
        end
      end
      ST_LATCH: begin
        state_d = ST_SHOW;
      end
      ST_SHOW: begin
        if (show_done) begin
          if (plane_q != PLANE_LAST) begin
            plane_d   = plane_q + PL_W'(1);
            state_d   = ST_SHIFT;
            fb_addr_d = {row_q, {COL_W{1'b0}}};
          end else begin
            plane_d = '0;
            row_d   = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            if ((row_q == ROW_LAST) && !enable) begin
              state_d = ST_IDLE;
            end else begin
              state_d       = ST_SHIFT;
              fb_addr_d     = {row_d, {COL_W{1'b0}}};
              frame_start_d = (row_q == ROW_LAST);
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    sclk_d  = (state_q == ST_SHIFT) && !cnt_q[0] && (cnt_q != '0);
    latch_d = (state_d == ST_LATCH);
    blank_d = (state_d != ST_SHOW);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      row_q         <= '0;
      plane_q       <= '0;
      fb_addr_q     <= '0;
      rgb0_q        <= '0;
      rgb1_q        <= '0;
      sclk_q        <= 1'b0;
      latch_q       <= 1'b0;
      blank_q       <= 1'b1;
      addry_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      row_q         <= row_d;
      plane_q       <= plane_d;
      fb_addr_q     <= fb_addr_d;
      rgb0_q        <= rgb0_d;
      rgb1_q        <= rgb1_d;
      sclk_q        <= sclk_d;
      latch_q       <= latch_d;
      blank_q       <= blank_d;
      addry_q       <= addry_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign fb_addr     = fb_addr_q;
  assign rgb0        = rgb0_q;
  assign rgb1        = rgb1_q;
  assign sclk        = sclk_q;
  assign latch       = latch_q;
  assign blank       = blank_q;
  assign addry       = addry_q;
  assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_hub75_bcm_scheduler.sv
`default_nettype none
// ==========================================================================
// tb_hub75_bcm_scheduler -- scoreboard bench against a frame-level panel model
// Revision: 1.0
// ==========================================================================
module tb_hub75_bcm_scheduler;

  localparam int WIDTH     = 64;
  localparam int ROWS      = 32;
  localparam int BITS      = 4;
  localparam int BASE      = 8;
  localparam int ROW_CYC   = BITS * (2 * WIDTH + 3) + BASE * ((1 << BITS) - 1);
  localparam int FRAME_CYC = ROWS * ROW_CYC;
  localparam int NPIX      = ROWS * WIDTH;

  localparam int EV_FS    = 0;
  localparam int EV_SCLK  = 1;
  localparam int EV_LATCH = 2;
  localparam int EV_SHOW  = 3;

  typedef struct packed {
    int kind;
    int v0;
    int v1;
    int plane;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [10:0] fb_addr;
  logic [11:0] fb_data0 = '0;
  logic [11:0] fb_data1 = '0;
  logic [2:0]  rgb0, rgb1;
  logic        sclk, latch, blank, frame_start;
  logic [4:0]  addry;

  logic [11:0] mem0 [NPIX];
  logic [11:0] mem1 [NPIX];
  logic [11:0] nx0  [NPIX];
  logic [11:0] nx1  [NPIX];

  ev_t sb[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;

  hub75_bcm_scheduler #(
    .WIDTH (WIDTH),
    .ROWS  (ROWS),
    .BITS  (BITS),
    .BASE  (BASE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .fb_addr     (fb_addr),
    .fb_data0    (fb_data0),
    .fb_data1    (fb_data1),
    .rgb0        (rgb0),
    .rgb1        (rgb1),
    .sclk        (sclk),
    .latch       (latch),
    .blank       (blank),
    .addry       (addry),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    fb_data0 <= mem0[fb_addr];
    fb_data1 <= mem1[fb_addr];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Panel model: a plane is WIDTH shifted pixels, one latch of the row, then BASE<<p lit cycles.
  task automatic push_plane(input int r, input int p, input bit use_nx, input bit with_show);
    ev_t e;
    logic [11:0] u, l;
    int a;
    for (int k = 0; k < WIDTH; k++) begin
      a = r * WIDTH + k;
      u = use_nx ? nx0[a] : mem0[a];
      l = use_nx ? nx1[a] : mem1[a];
      e.kind  = EV_SCLK;
      e.v0    = int'({u[2*BITS+p], u[BITS+p], u[p]});
      e.v1    = int'({l[2*BITS+p], l[BITS+p], l[p]});
      e.plane = p;
      sb.push_back(e);
    end
    e.kind = EV_LATCH; e.v0 = r; e.v1 = 0; e.plane = p;
    sb.push_back(e);
    if (with_show) begin
      e.kind = EV_SHOW; e.v0 = BASE * (1 << p); e.v1 = 0; e.plane = p;
      sb.push_back(e);
    end
  endtask

  task automatic push_fs();
    ev_t e;
    e.kind = EV_FS; e.v0 = 0; e.v1 = 0; e.plane = 0;
    sb.push_back(e);
  endtask

  task automatic push_rows(input int nrows, input bit use_nx);
    push_fs();
    for (int r = 0; r < nrows; r++)
      for (int p = 0; p < BITS; p++)
        push_plane(r, p, use_nx, 1'b1);
  endtask

  task automatic pop(input int kind, output ev_t e, output bit ok);
    ok = 1'b0;
    e  = '0;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d, expected none (cycle %0d)", kind, cyc);
    end else begin
      e = sb.pop_front();
      chk("event_kind", kind, e.kind);
      ok = (kind == e.kind);
    end
  endtask

  // Monitor: samples on the falling edge and consumes one expectation per DUT event.
  int  low_cnt = 0, sclk_since = 0, last_p0 = -1, lat_in_frame = 0, fs_cnt = 0, nz1 = 0;
  int  prev_addry = 0;
  int  nz_where[$];
  ev_t me;
  bit  mok;

  always @(negedge clk) begin
    if (reset) begin
      low_cnt      = 0;
      sclk_since   = 0;
      last_p0      = -1;
      lat_in_frame = 0;
      prev_addry   = int'(addry);
    end else begin
      if (int'(addry) != prev_addry) begin
        chk("addry_change_only_in_latch", int'(latch), 1);
        chk("addry_step", int'(addry), (prev_addry + 1) % ROWS);
      end
      prev_addry = int'(addry);
      if (!blank) begin
        low_cnt++;
      end else if (low_cnt > 0) begin
        pop(EV_SHOW, me, mok);
        if (mok) chk("show_len", low_cnt, me.v0);
        low_cnt = 0;
      end
      if (frame_start) begin
        fs_cnt++;
        pop(EV_FS, me, mok);
        last_p0      = -1;
        lat_in_frame = 0;
        sclk_since   = 0;
      end
      if (sclk) begin
        pop(EV_SCLK, me, mok);
        if (mok) begin
          chk("rgb0", int'(rgb0), me.v0);
          chk("rgb1", int'(rgb1), me.v1);
        end
        chk("blank_during_shift", int'(blank), 1);
        if (rgb0 != 3'b000) nz_where.push_back(lat_in_frame * WIDTH + sclk_since);
        if (rgb1 != 3'b000) nz1++;
        sclk_since++;
      end
      if (latch) begin
        pop(EV_LATCH, me, mok);
        if (mok) begin
          chk("latch_addry", int'(addry), me.v0);
          if (me.plane == 0) begin
            if (last_p0 >= 0) chk("row_period", cyc - last_p0, ROW_CYC);
            last_p0 = cyc;
          end
        end
        chk("sclk_per_latch", sclk_since, WIDTH);
        chk("blank_during_latch", int'(blank), 1);
        sclk_since = 0;
        lat_in_frame++;
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_blank"}, int'(blank), 1);
    chk({tag, "_sclk"}, int'(sclk), 0);
    chk({tag, "_latch"}, int'(latch), 0);
    chk({tag, "_rgb0"}, int'(rgb0), 0);
    chk({tag, "_rgb1"}, int'(rgb1), 0);
    chk({tag, "_addry"}, int'(addry), 0);
    chk({tag, "_fb_addr"}, int'(fb_addr), 0);
    chk({tag, "_frame_start"}, int'(frame_start), 0);
  endtask

  task automatic wait_fs(input int limit, output bit got);
    got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge clk);
      if (frame_start) got = 1'b1;
    end
  endtask

  task automatic wait_empty(input int limit, output bit got);
    got = (sb.size() == 0);
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge clk);
      #1;
      got = (sb.size() == 0);
    end
  endtask

  initial begin
    int f1, f2, f3, idle_fs, idle_low, idle_sclk;
    bit got;

    for (int a = 0; a < NPIX; a++) begin
      mem0[a] = '0;
      mem1[a] = '0;
    end
    mem0[3 * WIDTH + 5] = 12'h00A;

    repeat (3) @(negedge clk);
    check_reset("por");
    reset = 1'b0;
    @(negedge clk);
    chk("idle_blank", int'(blank), 1);
    chk("idle_no_fs", int'(frame_start), 0);

    // Frame 1: sparse directed pattern.
    push_rows(ROWS, 1'b0);
    enable = 1'b1;
    @(negedge clk);
    chk("fs_after_enable", int'(frame_start), 1);
    chk("first_fb_addr", int'(fb_addr), 0);
    f1 = cyc;

    for (int a = 0; a < NPIX; a++) begin
      nx0[a] = 12'($urandom);
      nx1[a] = 12'($urandom);
    end
    push_rows(ROWS, 1'b1);

    // Frame 2: random pixels, enable dropped mid-frame.
    wait_fs(FRAME_CYC + 20, got);
    chk("frame2_start_seen", int'(got), 1);
    chk("frame_period", cyc - f1, FRAME_CYC);
    for (int a = 0; a < NPIX; a++) begin
      mem0[a] = nx0[a];
      mem1[a] = nx1[a];
    end
    chk("sparse_rgb0_hits", nz_where.size(), 2);
    if (nz_where.size() > 0) chk("sparse_hit_plane1", nz_where[0], (3 * BITS + 1) * WIDTH + 5);
    if (nz_where.size() > 1) chk("sparse_hit_plane3", nz_where[1], (3 * BITS + 3) * WIDTH + 5);
    chk("sparse_rgb1_hits", nz1, 0);
    f2 = cyc;

    repeat (10 * ROW_CYC + 100) @(negedge clk);
    enable = 1'b0;
    wait_empty(FRAME_CYC, got);
    chk("frame2_drained", int'(got), 1);
    chk("frame2_length", cyc - f2, FRAME_CYC);

    idle_fs = 0; idle_low = 0; idle_sclk = 0;
    repeat (300) begin
      @(negedge clk);
      if (frame_start) idle_fs++;
      if (!blank) idle_low++;
      if (sclk) idle_sclk++;
    end
    chk("idle_fs_pulses", idle_fs, 0);
    chk("idle_unblanked_cycles", idle_low, 0);
    chk("idle_sclk_pulses", idle_sclk, 0);
    chk("total_frame_starts", fs_cnt, 2);

    // Frame 3: reset during SHOW of row 7, plane 2.
    for (int a = 0; a < NPIX; a++) begin
      mem0[a] = 12'($urandom);
      mem1[a] = 12'($urandom);
    end
    push_fs();
    for (int r = 0; r < 7; r++)
      for (int p = 0; p < BITS; p++)
        push_plane(r, p, 1'b0, 1'b1);
    push_plane(7, 0, 1'b0, 1'b1);
    push_plane(7, 1, 1'b0, 1'b1);
    push_plane(7, 2, 1'b0, 1'b0);
    enable = 1'b1;
    @(negedge clk);
    chk("fs_frame3", int'(frame_start), 1);
    f3 = cyc;
    repeat (7 * ROW_CYC + (2 * WIDTH + 3) * 3 + BASE * 3 + 10) @(negedge clk);
    chk("mid_show_blank", int'(blank), 0);
    chk("mid_show_addry", int'(addry), 7);
    reset  = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    check_reset("mid_show");
    @(negedge clk);
    reset = 1'b0;
    chk("queue_empty_at_reset", sb.size(), 0);
    @(negedge clk);
    chk("post_reset_idle_blank", int'(blank), 1);
    chk("post_reset_no_fs", int'(frame_start), 0);

    // Restart from row 0, plane 0.
    push_rows(2, 1'b0);
    enable = 1'b1;
    @(negedge clk);
    chk("fs_restart", int'(frame_start), 1);
    chk("restart_fb_addr", int'(fb_addr), 0);
    wait_empty(3 * ROW_CYC, got);
    chk("restart_drained", int'(got), 1);
    chk("restart_two_rows", cyc - f3 > 0 ? 1 : 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
